tdm_demux_4ch: RTL and testbench
================================

Name: tdm_demux_4ch

Overview:
Receive end of the 4-channel select/mux path. It takes a single serial time-division line carrying one bit per slot from channels A, B, C and D in that order, with the slot index encoded as {s1,s0}. It acquires frame alignment from a sync marker, flywheels through sync errors, and deserializes each channel into WORD_BITS-wide words with per-channel valid strobes.

Parameters:
WORD_BITS, 8, bits per deserialized channel word (>=2)
LOCK_FRAMES, 2, consecutive aligned syncs needed to declare lock (>=1)
LOSS_FRAMES, 2, sync error events in LOCKED before dropping to HUNT (>=1)

Ports:
clk  input  1  single system clock; everything on rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  slot strobe; state advances and din/sync are sampled only on edges with en=1
din  input  1  serial TDM data bit
sync  input  1  frame marker; 1 coincident with the slot-0 (channel A) bit
slot  output  2  index of the slot sampled at the next en ({s1,s0}: 0=A, 1=B, 2=C, 3=D)
locked  output  1  1 while in LOCKED
ch_a, ch_b, ch_c, ch_d  output  WORD_BITS each  last completed word per channel, MSB first
ch_valid  output  4  bit i pulses for one clk when word i updates (bit0=A)
sync_err  output  1  one-clk pulse per sync error event in LOCKED

Behaviour:
- Reset (rst_n=0 at an edge, any state, overrides en): state HUNT, slot=0, all counters and shift registers 0, ch_* = 0, ch_valid = 0, locked = 0, sync_err = 0. Partial words are discarded.
- All outputs are registered. ch_valid and sync_err are high for exactly one clk regardless of en spacing.
- With en=0, no state, counter or ch_* changes occur. Pulses from the previous edge still clear.
- HUNT: slot is held at 0 and no data is captured. On en&sync: go to CHECK, slot<=1, good_cnt<=1.
- CHECK: slot increments mod 4 on every en. No data is captured.
  - en at slot 0 with sync: good_cnt++. If the incremented value equals LOCK_FRAMES, go to LOCKED, clear all bit counters, and capture this din as bit 1 of channel A.
  - en at slot 0 without sync: go to HUNT.
  - en&sync at slot!=0: restart CHECK treating this bit as slot 0 (slot<=1, good_cnt<=1).
  - LOCK_FRAMES=1: the first sync in HUNT goes straight to LOCKED and captures that bit.
- LOCKED: slot increments mod 4 on every en. din is shifted into channel[slot]: sh <= {sh[W-2:0],din}, and that channel's bit count increments.
  - On the WORD_BITS-th bit: ch_x <= {sh,din}, ch_valid[x] pulses, the count resets to 0.
  - Channels complete in order A, B, C, D on consecutive en strobes.
  - Sync error event: en at slot 0 without sync, or en&sync at slot!=0. It pulses sync_err and increments miss_cnt. Data capture continues at the current flywheel alignment.
  - en at slot 0 with sync: clears miss_cnt.
  - When miss_cnt reaches LOSS_FRAMES: go to HUNT on that edge, slot<=0, locked<=0, bit counters and shift registers cleared, ch_* hold their last values, and the bit on that edge is not captured.
- Only one transition is taken per en; the error/loss check takes priority over data capture.
- Width rule: counters are sized $clog2(WORD_BITS+1) and $clog2(max(LOCK_FRAMES,LOSS_FRAMES)+1). The slot counter is 2 bits and wraps naturally.

Decomposition:
- Package tdm_pkg:
  - state typedef enum {HUNT, CHECK, LOCKED}
  - slot_t (2-bit)
  - constants SLOT_A=0, SLOT_B=1, SLOT_C=2, SLOT_D=3, NUM_CH=4
- Sub-module tdm_ch_deser (params WORD_BITS):
  - contents: shift register, bit counter, output word register, valid pulse
  - inputs: clk, rst_n, shift_en, clr, din
  - instantiated 4 times; the top holds the FSM, slot counter and sync checking

Test Plan:
1. Reset: rst_n=0 for 3 clks with en=1, sync=1, din=1 -> ch_*=0, ch_valid=0, slot=0, locked=0, sync_err=0.
2. Acquisition: en every clk, sync every 4th en -> CHECK after the 1st sync; locked=1 after the edge sampling the 2nd sync; slot cycles 0,1,2,3.
3. Data after lock, 8 frames with constant A=0, B=1, C=1, D=0 -> ch_a=8'h00, ch_b=8'hFF, ch_c=8'hFF, ch_d=8'h00. ch_valid pulses 0001, 0010, 0100, 1000 on consecutive en. Next 8 frames with A=8'hA5 MSB first -> ch_a=8'hA5.
4. en asserted every 3rd clk, same stimulus as 3 -> identical words; each ch_valid pulse exactly 1 clk wide; slot frozen between strobes.
5. Loss: in LOCKED, omit sync for 2 frames mid-word -> sync_err pulses at each slot 0; locked falls on the 2nd; ch_a stays 8'hA5; no ch_valid pulse. Re-lock after 2 aligned syncs; the first new word is complete and correct.
6. Misalignment and reset:
   - In CHECK, sync at slot 2 -> CHECK restarts, slot=1 next; lock follows only 1 further aligned sync (restart counts as the 1st).
   - rst_n=0 for 1 clk mid-word in LOCKED -> all outputs 0, HUNT.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-channel TDM receive path.
// Slot indices, FSM states and a small sizing helper.
package tdm_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_A = 2'd0;
    localparam slot_t SLOT_B = 2'd1;
    localparam slot_t SLOT_C = 2'd2;
    localparam slot_t SLOT_D = 2'd3;
    localparam int    NUM_CH = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tdm_ch_deser.sv
// Per-channel deserializer: MSB-first shift register, bit counter,
// word register and a one-clock valid strobe on word completion.
module tdm_ch_deser #(
    parameter int WORD_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_shift_en,
    input  logic                 i_clr,
    input  logic                 i_din,
    output logic [WORD_BITS-1:0] o_word,
    output logic                 o_valid
);

    localparam int CW = $clog2(WORD_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

    logic [WORD_BITS-1:0] r_sh;
    logic [WORD_BITS-1:0] r_word;
    logic [CW-1:0]        r_cnt;
    logic                 r_valid;

    logic [WORD_BITS-1:0] w_sh_base;
    logic [WORD_BITS-1:0] w_sh_nxt;
    logic [CW-1:0]        w_cnt_base;

    // A clear coincident with a shift starts a fresh word with this bit
    assign w_sh_base  = i_clr ? '0 : r_sh;
    assign w_cnt_base = i_clr ? '0 : r_cnt;
    assign w_sh_nxt   = {w_sh_base[WORD_BITS-2:0], i_din};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sh    <= '0;
            r_word  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_shift_en) begin
                r_sh <= w_sh_nxt;
                if (w_cnt_base == LAST) begin
                    r_word  <= w_sh_nxt;
                    r_valid <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= w_cnt_base + CW'(1);
                end
            end else if (i_clr) begin
                r_sh  <= '0;
                r_cnt <= '0;
            end
        end
    end

    assign o_word  = r_word;
    assign o_valid = r_valid;

endmodule

// File: rtl/tdm_demux_4ch.sv
// 4-channel TDM receiver: sync acquisition, flywheel lock tracking
// and per-channel word deserialization.
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int WORD_BITS   = 8,
    parameter int LOCK_FRAMES = 2,
    parameter int LOSS_FRAMES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_din,
    input  logic                 i_sync,
    output logic [1:0]           o_slot,
    output logic                 o_locked,
    output logic [WORD_BITS-1:0] o_ch_a,
    output logic [WORD_BITS-1:0] o_ch_b,
    output logic [WORD_BITS-1:0] o_ch_c,
    output logic [WORD_BITS-1:0] o_ch_d,
    output logic [3:0]           o_ch_valid,
    output logic                 o_sync_err
);

    localparam int CW = $clog2(max2(LOCK_FRAMES, LOSS_FRAMES) + 1);
    localparam logic [CW-1:0] LOCK_V = CW'(LOCK_FRAMES);
    localparam logic [CW-1:0] LOSS_V = CW'(LOSS_FRAMES);

    state_t        r_state;
    state_t        w_state_nxt;
    slot_t         r_slot;
    slot_t         w_slot_nxt;
    logic [CW-1:0] r_good;
    logic [CW-1:0] w_good_nxt;
    logic [CW-1:0] w_good_inc;
    logic [CW-1:0] r_miss;
    logic [CW-1:0] w_miss_nxt;
    logic [CW-1:0] w_miss_inc;
    logic          r_locked;
    logic          r_sync_err;
    logic          w_bad;
    logic          w_err;
    logic          w_capture;
    logic          w_clr;
    logic [NUM_CH-1:0] w_shift;

    logic [WORD_BITS-1:0] w_word [NUM_CH];
    logic [NUM_CH-1:0]    w_valid;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= HUNT;
            r_slot     <= SLOT_A;
            r_good     <= '0;
            r_miss     <= '0;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_slot     <= w_slot_nxt;
            r_good     <= w_good_nxt;
            r_miss     <= w_miss_nxt;
            r_locked   <= (w_state_nxt == LOCKED);
            r_sync_err <= w_err;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_good_nxt  = r_good;
        w_miss_nxt  = r_miss;
        w_capture   = 1'b0;
        w_clr       = 1'b0;
        w_err       = 1'b0;
        w_good_inc  = r_good + CW'(1);
        w_miss_inc  = r_miss + CW'(1);
        w_bad       = (r_slot == SLOT_A) ^ i_sync;
        if (i_en) begin
            unique case (r_state)
                HUNT: begin
                    if (i_sync) begin
                        w_slot_nxt = SLOT_B;
                        w_good_nxt = CW'(1);
                        if (LOCK_FRAMES == 1) begin
                            w_state_nxt = LOCKED;
                            w_clr       = 1'b1;
                            w_capture   = 1'b1;
                            w_miss_nxt  = '0;
                        end else begin
                            w_state_nxt = CHECK;
                        end
                    end
                end
                CHECK: begin
                    w_slot_nxt = r_slot + 2'd1;
                    if (r_slot == SLOT_A) begin
                        if (i_sync) begin
                            w_good_nxt = w_good_inc;
                            if (w_good_inc == LOCK_V) begin
                                w_state_nxt = LOCKED;
                                w_clr       = 1'b1;
                                w_capture   = 1'b1;
                                w_miss_nxt  = '0;
                            end
                        end else begin
                            w_state_nxt = HUNT;
                            w_slot_nxt  = SLOT_A;
                            w_good_nxt  = '0;
                        end
                    end else if (i_sync) begin
                        // Early sync: treat this bit as the new slot 0
                        w_slot_nxt = SLOT_B;
                        w_good_nxt = CW'(1);
                    end
                end
                LOCKED: begin
                    w_slot_nxt = r_slot + 2'd1;
                    w_capture  = 1'b1;
                    if (w_bad) begin
                        w_err      = 1'b1;
                        w_miss_nxt = w_miss_inc;
                        if (w_miss_inc == LOSS_V) begin
                            w_state_nxt = HUNT;
                            w_slot_nxt  = SLOT_A;
                            w_capture   = 1'b0;
                            w_clr       = 1'b1;
                            w_miss_nxt  = '0;
                            w_good_nxt  = '0;
                        end
                    end else if (r_slot == SLOT_A) begin
                        w_miss_nxt = '0;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        w_shift = '0;
        if (w_capture) begin
            unique case (1'b1)
                (r_slot == SLOT_A): w_shift[0] = 1'b1;
                (r_slot == SLOT_B): w_shift[1] = 1'b1;
                (r_slot == SLOT_C): w_shift[2] = 1'b1;
                (r_slot == SLOT_D): w_shift[3] = 1'b1;
                default:            w_shift    = '0;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tdm_ch_deser #(
            .WORD_BITS(WORD_BITS)
        ) u_deser (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_shift_en(w_shift[g]),
            .i_clr     (w_clr),
            .i_din     (i_din),
            .o_word    (w_word[g]),
            .o_valid   (w_valid[g])
        );
    end

    assign o_slot     = r_slot;
    assign o_locked   = r_locked;
    assign o_sync_err = r_sync_err;
    assign o_ch_valid = w_valid;
    assign o_ch_a     = w_word[SLOT_A];
    assign o_ch_b     = w_word[SLOT_B];
    assign o_ch_c     = w_word[SLOT_C];
    assign o_ch_d     = w_word[SLOT_D];

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Randomized bench for tdm_demux_4ch against a frame-level reference
// model, plus directed acquisition, loss, realignment and reset checks.
module tb_tdm_demux_4ch;

    localparam int W    = 8;
    localparam int LOCK = 2;
    localparam int LOSS = 2;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b0;
    logic         din   = 1'b0;
    logic         sync  = 1'b0;
    logic [1:0]   slot;
    logic         locked;
    logic         sync_err;
    logic [W-1:0] ch_a;
    logic [W-1:0] ch_b;
    logic [W-1:0] ch_c;
    logic [W-1:0] ch_d;
    logic [3:0]   ch_valid;

    always #5 clk = ~clk;

    tdm_demux_4ch #(
        .WORD_BITS  (W),
        .LOCK_FRAMES(LOCK),
        .LOSS_FRAMES(LOSS)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_din     (din),
        .i_sync    (sync),
        .o_slot    (slot),
        .o_locked  (locked),
        .o_ch_a    (ch_a),
        .o_ch_b    (ch_b),
        .o_ch_c    (ch_c),
        .o_ch_d    (ch_d),
        .o_ch_valid(ch_valid),
        .o_sync_err(sync_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: mode 0=hunt 1=check 2=locked
    int m_mode = 0;
    int m_slot = 0;
    int m_good = 0;
    int m_miss = 0;
    int m_cnt  [4];
    int m_acc  [4];
    int m_word [4];
    int m_valid = 0;
    int m_err   = 0;

    task automatic m_clear_bits();
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = 0;
            m_acc[c] = 0;
        end
    endtask

    task automatic m_capture(input int c, input int b);
        m_acc[c] = ((m_acc[c] * 2) + b) % (1 << W);
        m_cnt[c]++;
        if (m_cnt[c] == W) begin
            m_word[c] = m_acc[c];
            m_valid   = m_valid | (1 << c);
            m_cnt[c]  = 0;
        end
    endtask

    task automatic m_enter_lock(input int b);
        m_mode = 2;
        m_slot = 1;
        m_miss = 0;
        m_clear_bits();
        m_capture(0, b);
    endtask

    task automatic model_edge();
        int s;
        int d;
        int bad;
        s = int'(sync);
        d = int'(din);
        if (!rst_n) begin
            m_mode = 0; m_slot = 0; m_good = 0; m_miss = 0;
            m_clear_bits();
            for (int c = 0; c < 4; c++) m_word[c] = 0;
            m_valid = 0;
            m_err   = 0;
            return;
        end
        m_valid = 0;
        m_err   = 0;
        if (!en) return;
        if (m_mode == 0) begin
            if (s == 1) begin
                if (LOCK == 1) m_enter_lock(d);
                else begin
                    m_mode = 1; m_slot = 1; m_good = 1;
                end
            end
        end else if (m_mode == 1) begin
            if (m_slot == 0 && s == 1) begin
                m_good++;
                if (m_good == LOCK) m_enter_lock(d);
                else m_slot = 1;
            end else if (m_slot == 0) begin
                m_mode = 0; m_slot = 0; m_good = 0;
            end else if (s == 1) begin
                m_slot = 1; m_good = 1;
            end else begin
                m_slot = (m_slot + 1) % 4;
            end
        end else begin
            bad = ((m_slot == 0) != (s == 1)) ? 1 : 0;
            if (bad == 1) begin
                m_err = 1;
                m_miss++;
                if (m_miss == LOSS) begin
                    m_mode = 0; m_slot = 0; m_miss = 0; m_good = 0;
                    m_clear_bits();
                    return;
                end
            end else if (m_slot == 0) begin
                m_miss = 0;
            end
            m_capture(m_slot, d);
            m_slot = (m_slot + 1) % 4;
        end
    endtask

    task automatic compare_all();
        chk("slot",     32'(slot),     32'(m_slot));
        chk("locked",   32'(locked),   32'(m_mode == 2));
        chk("sync_err", 32'(sync_err), 32'(m_err));
        chk("ch_valid", 32'(ch_valid), 32'(m_valid));
        chk("ch_a",     32'(ch_a),     32'(m_word[0]));
        chk("ch_b",     32'(ch_b),     32'(m_word[1]));
        chk("ch_c",     32'(ch_c),     32'(m_word[2]));
        chk("ch_d",     32'(ch_d),     32'(m_word[3]));
    endtask

    task automatic tick(input logic e, input logic s, input logic d,
                        input logic r);
        @(negedge clk);
        en    = e;
        sync  = s;
        din   = d;
        rst_n = r;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Idle clocks carry random din/sync that must be ignored
    task automatic strobe(input logic s, input logic d, input int gap);
        for (int g = 1; g < gap; g++)
            tick(1'b0, 1'($urandom % 2), 1'($urandom % 2), 1'b1);
        tick(1'b1, s, d, 1'b1);
    endtask

    task automatic send_frame(input logic [3:0] bits, input logic s0,
                              input int gap);
        strobe(s0, bits[0], gap);
        strobe(1'b0, bits[1], gap);
        strobe(1'b0, bits[2], gap);
        strobe(1'b0, bits[3], gap);
    endtask

    task automatic send_words(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c, input logic [W-1:0] d,
                              input int gap);
        for (int i = W - 1; i >= 0; i--)
            send_frame({d[i], c[i], b[i], a[i]}, 1'b1, gap);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_slot"},  32'(slot),     0);
        chk({tag, "_lock"},  32'(locked),   0);
        chk({tag, "_err"},   32'(sync_err), 0);
        chk({tag, "_valid"}, 32'(ch_valid), 0);
        chk({tag, "_words"}, 32'(ch_a | ch_b | ch_c | ch_d), 0);
    endtask

    initial begin
        int p;
        logic s;

        // Reset overrides en/sync/din
        repeat (3) tick(1'b1, 1'b1, 1'b1, 1'b0);
        check_all_zero("reset");

        // Acquisition
        strobe(1'b1, 1'b0, 1);
        chk("acq_slot", 32'(slot), 1);
        chk("acq_nolock", 32'(locked), 0);
        strobe(1'b0, 1'b0, 1);
        chk("acq_slot2", 32'(slot), 2);
        strobe(1'b0, 1'b0, 1);
        strobe(1'b0, 1'b0, 1);
        chk("acq_slot0", 32'(slot), 0);
        send_words(8'h00, 8'hFF, 8'hFF, 8'h00, 1);
        chk("lock_held", 32'(locked), 1);
        chk("w1_a", 32'(ch_a), 32'h00);
        chk("w1_b", 32'(ch_b), 32'hFF);
        chk("w1_c", 32'(ch_c), 32'hFF);
        chk("w1_d", 32'(ch_d), 32'h00);
        send_words(8'hA5, 8'h5A, 8'h0F, 8'hF0, 1);
        chk("w2_a", 32'(ch_a), 32'hA5);

        // Sparse en strobes
        send_words(8'h00, 8'hFF, 8'hFF, 8'h00, 3);
        chk("g3_a", 32'(ch_a), 32'h00);
        chk("g3_b", 32'(ch_b), 32'hFF);
        chk("g3_c", 32'(ch_c), 32'hFF);
        chk("g3_d", 32'(ch_d), 32'h00);
        send_words(8'hA5, 8'h5A, 8'h0F, 8'hF0, 3);
        chk("g3_a5", 32'(ch_a), 32'hA5);

        // Loss of sync mid-word
        for (int i = 0; i < 3; i++) send_frame(4'b1010, 1'b1, 1);
        strobe(1'b0, 1'b1, 1);
        chk("loss1_err", 32'(sync_err), 1);
        chk("loss1_lock", 32'(locked), 1);
        for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0, 1);
        strobe(1'b0, 1'b1, 1);
        chk("loss2_err", 32'(sync_err), 1);
        chk("loss2_lock", 32'(locked), 0);
        chk("loss2_slot", 32'(slot), 0);
        for (int i = 0; i < 3; i++) strobe(1'b0, 1'b1, 1);
        chk("loss_hold_a", 32'(ch_a), 32'hA5);

        // Re-lock, then reset mid-word
        send_frame(4'b0110, 1'b1, 1);
        send_words(8'hC3, 8'h3C, 8'h81, 8'h7E, 1);
        chk("relock_a", 32'(ch_a), 32'hC3);
        chk("relock_d", 32'(ch_d), 32'h7E);
        for (int i = 0; i < 3; i++) send_frame(4'b1111, 1'b1, 1);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check_all_zero("midrst");

        // Misaligned sync while checking
        strobe(1'b1, 1'b0, 1);
        strobe(1'b0, 1'b0, 1);
        strobe(1'b1, 1'b0, 1);
        chk("mis_slot", 32'(slot), 1);
        chk("mis_nolock", 32'(locked), 0);
        for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0, 1);
        strobe(1'b1, 1'b1, 1);
        chk("mis_lock", 32'(locked), 1);

        // Random traffic with occasional sync faults and resets
        p = 0;
        for (int n = 0; n < 1200; n++) begin
            if ($urandom % 600 == 0) begin
                tick(1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'b0);
                p = 0;
            end
            s = (p % 4 == 0) ? 1'b1 : 1'b0;
            if ($urandom % 40 == 0) s = ~s;
            strobe(s, 1'($urandom % 2), int'($urandom_range(1, 3)));
            p = ($urandom % 200 == 0) ? p + 2 : p + 1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
